// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the M-stage data-memory responder: FSM encodings and default latency.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_array.sv
// Byte-lane data storage: synchronous per-byte write, asynchronous word read, no reset.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  // One narrow array per byte lane keeps the write mask a plain per-lane enable.
  for (genvar b = 0; b < 4; b++) begin : gLane
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
      if (we[b]) mem[waddr] <= wdata[8*b +: 8];
    end

    assign rdata[8*b +: 8] = mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: posted single-cycle stores, wait-stated reads that stall the pipeline.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ren,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  input  logic        hold,
  output logic [31:0] rdata,
  output logic        stall
);

  stateT             state, stateNxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] latIdx;
  logic [ADDR_W-1:0] reqIdx;
  logic [31:0]       memRd;
  logic [3:0]        arrWe;
  logic              accept;
  logic              unusedAddr;

  // Upper address bits wrap and the byte offset is resolved upstream.
  assign reqIdx     = addr[ADDR_W+1:2];
  assign unusedAddr = ^{addr[31:ADDR_W+2], addr[1:0]};

  assign accept = (state == IDLE) && !flush && (|ren);
  assign arrWe  = ((state == IDLE) && !flush) ? wen : 4'b0000;

  dmem_array #(.ADDR_W(ADDR_W)) uArray (
    .clk  (clk),
    .we   (arrWe),
    .waddr(reqIdx),
    .wdata(wdata),
    .raddr(latIdx),
    .rdata(memRd)
  );

  always_comb begin
    stateNxt = state;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          stateNxt = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          stateNxt = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt == '0) stateNxt = DONE;
        end
      end
      DONE: begin
        if (flush || !hold) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      latIdx <= '0;
      rdata  <= '0;
    end else begin
      state <= stateNxt;
      if (accept) begin
        latIdx <= reqIdx;
        cnt    <= CNT_W'(WAIT_CYCLES);
      end
      // Read sampled after the write of the accept cycle has committed.
      if ((state == BUSY) && !flush) begin
        if (cnt != '0) cnt   <= cnt - CNT_W'(1);
        else           rdata <= memRd;
      end
    end
  end

endmodule
